gpredict_ctrl: RTL and testbench
================================

Name: gpredict_ctrl

Overview:
Sequencing controller for the global-history predictor. Arbitrates one single-port BHT between prediction lookups and in-order branch resolutions, and keeps speculative and architectural GHRs. Tracks in-flight predictions in a FIFO and raises a flush on mispredict. Sits between fetch/resolve logic and the BHT counter array.

Parameters:
GHR_W, 4, history length and BHT index width (BHT has 2^GHR_W entries)
DEPTH, 4, max in-flight predictions (power of 2, >=2)
TAG_W, 2, log2(DEPTH), width of the prediction tag

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
pred_req_valid  in  1  prediction request
pred_req_pc  in  8  branch PC
pred_req_ready  out  1  request accepted when valid&ready
pred_rsp_valid  out  1  one-cycle pulse, prediction result
pred_rsp_taken  out  1  predicted direction
pred_rsp_tag  out  TAG_W  FIFO slot of this prediction
res_valid  in  1  resolution of the oldest in-flight branch
res_taken  in  1  actual outcome
res_ready  out  1  resolution accepted when valid&ready
flush  out  1  one-cycle pulse after a mispredict
bht_en  out  1  BHT access this cycle
bht_we  out  1  1 = write, 0 = read
bht_idx  out  GHR_W  BHT index
bht_wdata  out  2  counter write value
bht_rdata  in  2  counter read data, valid the cycle after a read
inflight_cnt  out  TAG_W+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0): state IDLE, spec_ghr=arch_ghr=0, FIFO empty, all outputs 0. Reset during LOOKUP or FLUSH aborts the operation; no pred_rsp or flush is issued.
- FSM states: IDLE, LOOKUP, FLUSH. At most one BHT access per cycle.
- res_ready = IDLE & inflight_cnt!=0.
- pred_req_ready = IDLE & inflight_cnt!=DEPTH & !(res_valid & inflight_cnt!=0). Resolution has priority over prediction.
- Predict handshake in IDLE: bht_en=1, bht_we=0, bht_idx=spec_ghr (combinational, same cycle). Next state is LOOKUP.
- LOOKUP (exactly 1 cycle):
  - pred_rsp_valid=1, pred_rsp_taken=bht_rdata[1], pred_rsp_tag=write pointer.
  - Push {idx, bht_rdata, pred} into the FIFO.
  - spec_ghr <= {spec_ghr[GHR_W-2:0], pred}.
  - Next state is IDLE. Throughput is 1 prediction per 2 cycles.
- Resolve handshake in IDLE: pop the oldest entry; bht_en=1, bht_we=1, bht_idx=entry.idx in the same cycle.
  - bht_wdata = saturating update of entry.ctr: taken -> min(ctr+1,3); not taken -> max(ctr-1,0).
  - arch_ghr <= {arch_ghr[GHR_W-2:0], res_taken}.
- Mispredict (res_taken != entry.pred):
  - At the same edge: FIFO cleared entirely (inflight_cnt=0), spec_ghr <= new arch_ghr value, next state FLUSH.
  - FLUSH: flush=1 for 1 cycle, both ready outputs 0, then IDLE.
- Correct prediction: FIFO pops one entry, state stays IDLE, spec_ghr unchanged.
- Pointers wrap modulo DEPTH. Tags reuse slot numbers.
- The counter written back is the value captured at lookup. An intervening write to an aliased index is overwritten (accepted behaviour).
- Simultaneous pred_req_valid and res_valid with FIFO non-empty: only the resolution is accepted.

Optional Feature:
GPREDICT_CTRL_PC_XOR_EN:
- Defined: lookup index = spec_ghr XOR pred_req_pc[GHR_W-1:0] (gshare). The stored idx is that hashed value.
- Undefined: index = spec_ghr. The PC is ignored except for the handshake.

Test Plan:
- Reset, then one predict with bench BHT[0]=2 -> bht read idx 0; next cycle pred_rsp_valid=1, taken=1, tag=0; inflight_cnt=1; spec_ghr=0001.
- That branch resolved taken -> write idx 0, wdata=3; no flush; arch_ghr=0001; inflight_cnt=0.
- Four predicts with all counters =0 -> tags 0,1,2,3, all not-taken; inflight_cnt=4. A fifth request is held with pred_req_ready=0 until the first resolve.
- Two in flight (idx 0 then 0, ctr 0, pred 0); resolve first as taken -> wdata=1, flush=1 on the next cycle, inflight_cnt=0, spec_ghr=arch_ghr=0001. The next lookup uses idx 1.
- pred_req_valid and res_valid both high with inflight_cnt=1 -> res accepted, pred_req_ready=0; the predict is accepted on the following IDLE cycle.
- Reset pulsed low during LOOKUP -> no pred_rsp_valid, inflight_cnt=0. With PC_XOR_EN defined, spec_ghr=0011 and pc=8'h05 give bht_idx=0110.

Source files
------------

// File: rtl/gpredict_ctrl_if.sv
// Interfaces for the global-history predictor controller.
// gpredict_ctrl_if carries the fetch/resolve side, gpredict_bht_if the BHT side.
// The master drives requests, the slave (the controller, or the BHT) answers.

interface gpredict_ctrl_if #(
  parameter int TAG_W = 2
);
  logic             pred_req_valid;
  logic [7:0]       pred_req_pc;
  logic             pred_req_ready;
  logic             pred_rsp_valid;
  logic             pred_rsp_taken;
  logic [TAG_W-1:0] pred_rsp_tag;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             flush;
  logic [TAG_W:0]   inflight_cnt;

  modport master (
    output pred_req_valid, pred_req_pc, res_valid, res_taken,
    input  pred_req_ready, pred_rsp_valid, pred_rsp_taken, pred_rsp_tag,
           res_ready, flush, inflight_cnt
  );

  modport slave (
    input  pred_req_valid, pred_req_pc, res_valid, res_taken,
    output pred_req_ready, pred_rsp_valid, pred_rsp_taken, pred_rsp_tag,
           res_ready, flush, inflight_cnt
  );
endinterface

interface gpredict_bht_if #(
  parameter int GHR_W = 4
);
  logic             bht_en;
  logic             bht_we;
  logic [GHR_W-1:0] bht_idx;
  logic [1:0]       bht_wdata;
  logic [1:0]       bht_rdata;

  modport master (
    output bht_en, bht_we, bht_idx, bht_wdata,
    input  bht_rdata
  );

  modport slave (
    input  bht_en, bht_we, bht_idx, bht_wdata,
    output bht_rdata
  );
endinterface

// File: rtl/gpredict_ctrl.sv
// Sequencing controller for the global-history branch predictor.
// Shares one single-port BHT between lookups and in-order resolutions,
// keeps speculative/architectural GHRs and a FIFO of in-flight predictions.
// Optional build macro GPREDICT_CTRL_PC_XOR_EN: hash the lookup index as
// spec_ghr XOR pc (gshare); otherwise the index is spec_ghr alone.

module gpredict_ctrl #(
  parameter int GHR_W = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpredict_ctrl_if.slave   ctrl,
  gpredict_bht_if.master   bht
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [TAG_W:0] CNT_DEPTH = (TAG_W+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [GHR_W-1:0] r_spec_ghr;
  logic [GHR_W-1:0] r_arch_ghr;
  logic [GHR_W-1:0] r_lkp_idx;

  logic [GHR_W-1:0] r_fifo_idx  [DEPTH];
  logic [1:0]       r_fifo_ctr  [DEPTH];
  logic             r_fifo_pred [DEPTH];
  logic [TAG_W-1:0] r_wptr;
  logic [TAG_W-1:0] r_rptr;
  logic [TAG_W:0]   r_cnt;

  logic             w_idle;
  logic             w_empty;
  logic             w_full;
  logic             w_res_ready;
  logic             w_pred_ready;
  logic             w_res_fire;
  logic             w_pred_fire;
  logic             w_mispredict;
  logic [GHR_W-1:0] w_lkp_idx;
  logic [GHR_W-1:0] w_arch_nxt;
  logic [1:0]       w_head_ctr;
  logic [1:0]       w_upd_ctr;
  logic             w_pc_unused;

  assign w_idle     = (r_state == IDLE);
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CNT_DEPTH);
  assign w_head_ctr = r_fifo_ctr[r_rptr];
  assign w_arch_nxt = {r_arch_ghr[GHR_W-2:0], ctrl.res_taken};

  // Only the low index bits of the PC ever feed the hash; the rest is handshake-only.
  assign w_pc_unused = ^ctrl.pred_req_pc;

`ifdef GPREDICT_CTRL_PC_XOR_EN
  assign w_lkp_idx = r_spec_ghr ^ ctrl.pred_req_pc[GHR_W-1:0];
`else
  assign w_lkp_idx = r_spec_ghr;
`endif

  // Handshake qualification; resolutions win over predictions, nothing is accepted in reset.
  always_comb begin
    w_res_ready  = reset & w_idle & ~w_empty;
    w_pred_ready = reset & w_idle & ~w_full & ~(ctrl.res_valid & ~w_empty);
    w_res_fire   = ctrl.res_valid & w_res_ready;
    w_pred_fire  = ctrl.pred_req_valid & w_pred_ready;
    w_mispredict = w_res_fire & (ctrl.res_taken != r_fifo_pred[r_rptr]);
  end

  // Saturating 2-bit counter update of the value captured at lookup time.
  always_comb begin
    w_upd_ctr = w_head_ctr;
    if (ctrl.res_taken) begin
      if (w_head_ctr != 2'd3) w_upd_ctr = w_head_ctr + 2'd1;
    end else begin
      if (w_head_ctr != 2'd0) w_upd_ctr = w_head_ctr - 2'd1;
    end
  end

  // Next-state logic and all externally visible outputs.
  always_comb begin
    w_state_nxt         = r_state;
    ctrl.pred_req_ready = w_pred_ready;
    ctrl.res_ready      = w_res_ready;
    ctrl.pred_rsp_valid = 1'b0;
    ctrl.pred_rsp_taken = 1'b0;
    ctrl.pred_rsp_tag   = '0;
    ctrl.flush          = 1'b0;
    ctrl.inflight_cnt   = r_cnt;
    bht.bht_en          = 1'b0;
    bht.bht_we          = 1'b0;
    bht.bht_idx         = '0;
    bht.bht_wdata       = 2'd0;

    case (r_state)
      IDLE: begin
        if (w_res_fire) begin
          bht.bht_en    = 1'b1;
          bht.bht_we    = 1'b1;
          bht.bht_idx   = r_fifo_idx[r_rptr];
          bht.bht_wdata = w_upd_ctr;
          if (w_mispredict) w_state_nxt = FLUSH;
        end else if (w_pred_fire) begin
          bht.bht_en  = 1'b1;
          bht.bht_idx = w_lkp_idx;
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        ctrl.pred_rsp_valid = 1'b1;
        ctrl.pred_rsp_taken = bht.bht_rdata[1];
        ctrl.pred_rsp_tag   = r_wptr;
        w_state_nxt         = IDLE;
      end
      FLUSH: begin
        ctrl.flush  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any lookup or pending flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Remember the index of the accepted lookup so it can be stored with its result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_lkp_idx <= '0;
    else if (w_pred_fire) r_lkp_idx <= w_lkp_idx;
  end

  // In-flight FIFO: push on the lookup response, pop on resolve, wipe on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_idx[i]  <= '0;
        r_fifo_ctr[i]  <= 2'd0;
        r_fifo_pred[i] <= 1'b0;
      end
    end else if (r_state == LOOKUP) begin
      r_fifo_idx[r_wptr]  <= r_lkp_idx;
      r_fifo_ctr[r_wptr]  <= bht.bht_rdata;
      r_fifo_pred[r_wptr] <= bht.bht_rdata[1];
      r_wptr              <= r_wptr + TAG_W'(1);
      r_cnt               <= r_cnt + (TAG_W+1)'(1);
    end else if (w_res_fire) begin
      if (w_mispredict) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        r_rptr <= r_rptr + TAG_W'(1);
        r_cnt  <= r_cnt - (TAG_W+1)'(1);
      end
    end
  end

  // History registers: speculative shifts in predictions, architectural in outcomes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spec_ghr <= '0;
      r_arch_ghr <= '0;
    end else begin
      if (r_state == LOOKUP) r_spec_ghr <= {r_spec_ghr[GHR_W-2:0], bht.bht_rdata[1]};
      if (w_res_fire) begin
        r_arch_ghr <= w_arch_nxt;
        if (w_mispredict) r_spec_ghr <= w_arch_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gpredict_ctrl.sv
// Self-checking bench for gpredict_ctrl: a BHT memory model answers the
// controller, and a queue-based reference predicts every output each cycle.

module tb_gpredict_ctrl;

  localparam int GHR_W = 4;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int MASK  = (1 << GHR_W) - 1;
`ifdef GPREDICT_CTRL_PC_XOR_EN
  localparam bit PC_XOR = 1'b1;
`else
  localparam bit PC_XOR = 1'b0;
`endif

  typedef struct {
    int idx;
    int ctr;
    bit pred;
  } entry_t;

  logic clk;
  logic reset;

  gpredict_ctrl_if #(.TAG_W(TAG_W)) cif ();
  gpredict_bht_if  #(.GHR_W(GHR_W)) bif ();

  gpredict_ctrl #(.GHR_W(GHR_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (cif.slave),
    .bht   (bif.master)
  );

  int assertCount = 0;
  int failCount   = 0;

  entry_t q[$];
  int     specGhr, archGhr, nextTag, pendIdx, pendCtr;
  bit     pendRsp, pendFlush;
  int     refBht[1 << GHR_W];

  // Starting counter contents, shared by the BHT model and the reference.
  function automatic int initCtr(int i);
    return (i == 0) ? 2 : ((i * 3) % 4);
  endfunction

  function automatic int lookupIdx(int ghr, logic [7:0] pc);
    int hashed;
    hashed = (ghr ^ int'(pc)) & MASK;
    return PC_XOR ? hashed : ghr;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port BHT with one-cycle read latency.
  logic [1:0] bhtMem[1 << GHR_W];
  initial begin
    for (int i = 0; i < (1 << GHR_W); i++) bhtMem[i] = 2'(initCtr(i));
    bif.bht_rdata = 2'd0;
    forever begin
      @(posedge clk);
      if (bif.bht_en) begin
        if (bif.bht_we) bhtMem[bif.bht_idx] = bif.bht_wdata;
        else            bif.bht_rdata <= bhtMem[bif.bht_idx];
      end
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    q.delete();
    specGhr   = 0;
    archGhr   = 0;
    nextTag   = 0;
    pendRsp   = 1'b0;
    pendFlush = 1'b0;
    pendIdx   = 0;
    pendCtr   = 0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the reference at the rising edge.
  task automatic applyStimulus(input bit pv, input logic [7:0] pc, input bit rv, input bit rt);
    bit     idle, expPred, expRes, resFire, predFire;
    int     n, expWdata, li;
    entry_t e;
    idle     = !pendRsp && !pendFlush;
    n        = q.size();
    expRes   = idle && (n != 0);
    expPred  = idle && (n != DEPTH) && !(rv && n != 0);
    resFire  = rv && expRes;
    predFire = pv && expPred;
    li       = lookupIdx(specGhr, pc);
    expWdata = 0;
    if (resFire) begin
      e = q[0];
      expWdata = rt ? ((e.ctr == 3) ? 3 : e.ctr + 1) : ((e.ctr == 0) ? 0 : e.ctr - 1);
    end

    cif.pred_req_valid = pv;
    cif.pred_req_pc    = pc;
    cif.res_valid      = rv;
    cif.res_taken      = rt;
    #1;
    checkOutput("pred_req_ready", int'(cif.pred_req_ready), int'(expPred));
    checkOutput("res_ready", int'(cif.res_ready), int'(expRes));
    checkOutput("inflight_cnt", int'(cif.inflight_cnt), n);
    checkOutput("flush", int'(cif.flush), int'(pendFlush));
    checkOutput("pred_rsp_valid", int'(cif.pred_rsp_valid), int'(pendRsp));
    if (pendRsp) begin
      checkOutput("pred_rsp_taken", int'(cif.pred_rsp_taken), pendCtr >> 1);
      checkOutput("pred_rsp_tag", int'(cif.pred_rsp_tag), nextTag);
    end
    checkOutput("bht_en", int'(bif.bht_en), int'(resFire || predFire));
    if (resFire) begin
      checkOutput("bht_we_res", int'(bif.bht_we), 1);
      checkOutput("bht_idx_res", int'(bif.bht_idx), e.idx);
      checkOutput("bht_wdata", int'(bif.bht_wdata), expWdata);
    end else if (predFire) begin
      checkOutput("bht_we_pred", int'(bif.bht_we), 0);
      checkOutput("bht_idx_pred", int'(bif.bht_idx), li);
    end

    @(posedge clk);
    pendFlush = 1'b0;
    if (pendRsp) begin
      q.push_back('{idx: pendIdx, ctr: pendCtr, pred: (pendCtr >= 2)});
      specGhr = ((specGhr << 1) | ((pendCtr >= 2) ? 1 : 0)) & MASK;
      nextTag = (nextTag + 1) % DEPTH;
      pendRsp = 1'b0;
    end
    if (resFire) begin
      void'(q.pop_front());
      refBht[e.idx] = expWdata;
      archGhr = ((archGhr << 1) | int'(rt)) & MASK;
      if (rt != e.pred) begin
        q.delete();
        specGhr   = archGhr;
        nextTag   = 0;
        pendFlush = 1'b1;
      end
    end else if (predFire) begin
      pendIdx = li;
      pendCtr = refBht[li];
      pendRsp = 1'b1;
    end
    @(negedge clk);
  endtask

  // Random traffic; resolutions usually agree with the prediction so the FIFO can fill.
  task automatic randomPhase(input int cycles, input int predPct, input int resPct);
    bit rt;
    for (int c = 0; c < cycles; c++) begin
      if (q.size() > 0 && $urandom_range(0, 9) < 8) rt = q[0].pred;
      else                                          rt = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 99) < predPct, 8'($urandom),
                    $urandom_range(0, 99) < resPct, rt);
    end
  endtask

  // Get the controller into its lookup cycle, then pulse reset and expect everything aborted.
  task automatic resetDuringLookup();
    for (int k = 0; k < 40; k++) begin
      if (pendRsp) break;
      if (q.size() == DEPTH) applyStimulus(1'b0, 8'h00, 1'b1, q[0].pred);
      else                   applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    checkOutput("lookup_reached", int'(pendRsp), 1);
    reset = 1'b0;
    cif.pred_req_valid = 1'b0;
    cif.res_valid      = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", int'(cif.pred_rsp_valid), 0);
    checkOutput("rst_inflight", int'(cif.inflight_cnt), 0);
    checkOutput("rst_flush", int'(cif.flush), 0);
    checkOutput("rst_bht_en", int'(bif.bht_en), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rsp_valid_hold", int'(cif.pred_rsp_valid), 0);
    reset = 1'b1;
    resetModel();
  endtask

  initial begin
    for (int i = 0; i < (1 << GHR_W); i++) refBht[i] = initCtr(i);
    resetModel();
    reset = 1'b0;
    cif.pred_req_valid = 1'b1;
    cif.pred_req_pc    = 8'h00;
    cif.res_valid      = 1'b1;
    cif.res_taken      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_pred_req_ready", int'(cif.pred_req_ready), 0);
    checkOutput("reset_res_ready", int'(cif.res_ready), 0);
    checkOutput("reset_rsp_valid", int'(cif.pred_rsp_valid), 0);
    checkOutput("reset_flush", int'(cif.flush), 0);
    checkOutput("reset_bht_en", int'(bif.bht_en), 0);
    checkOutput("reset_inflight", int'(cif.inflight_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    // First prediction reads BHT[0]=2, resolves taken and saturates to 3.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

    // Fill the FIFO, then hold an extra request while full.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    // Request and resolution together: only the resolution goes through.
    applyStimulus(1'b1, 8'h33, 1'b1, q[0].pred);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    // Wrong outcome on the oldest entry forces a flush.
    applyStimulus(1'b0, 8'h00, 1'b1, !q[0].pred);
    applyStimulus(1'b1, 8'h5a, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    randomPhase(600, 80, 20);
    resetDuringLookup();
    randomPhase(600, 50, 50);
    resetDuringLookup();
    randomPhase(600, 30, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
